// File: rtl/vc_read_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vc_read_scheduler: credit-gated round-robin dequeue scheduler, one read   |
// | in flight, registered downstream hold and read timeout.  Revision: 1.0    |
// +---------------------------------------------------------------------------+
module vc_read_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUF_BITS     = 1,
  parameter int CREDIT_BITS  = 3,
  parameter int INIT_CREDITS = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [(1<<BUF_BITS)-1:0]  buf_empty,
  output logic                      buf_rdEn,
  output logic [BUF_BITS-1:0]       buf_read_vc,
  input  logic [DATA_WIDTH-1:0]     buf_read_data,
  input  logic [BUF_BITS-1:0]       buf_out_vc,
  input  logic                      buf_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [BUF_BITS-1:0]       out_vc,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      credit_in,
  input  logic [BUF_BITS-1:0]       credit_vc,
  output logic                      timeout_err
);

  localparam int N      = 1 << BUF_BITS;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CREDIT_BITS-1:0] C_CREDIT_MAX  = {CREDIT_BITS{1'b1}};
  localparam logic [CREDIT_BITS-1:0] C_CREDIT_INIT = CREDIT_BITS'(INIT_CREDITS);
  localparam logic [WAIT_W-1:0]      C_WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic                              rd_en_q, rd_en_d;
  logic [BUF_BITS-1:0]               read_vc_q, read_vc_d;
  logic [DATA_WIDTH-1:0]             out_data_q, out_data_d;
  logic [BUF_BITS-1:0]               out_vc_q, out_vc_d;
  logic                              out_valid_q, out_valid_d;
  logic                              timeout_q, timeout_d;
  logic [BUF_BITS-1:0]               rr_ptr_q, rr_ptr_d;
  logic [BUF_BITS-1:0]               cur_vc_q, cur_vc_d;
  logic [WAIT_W-1:0]                 wait_cnt_q, wait_cnt_d;
  logic [N-1:0][CREDIT_BITS-1:0]     credit_q, credit_d;

  logic                              w_found;
  logic [BUF_BITS-1:0]               w_grant_vc;
  logic [BUF_BITS-1:0]               w_cand;
  logic                              w_grant;
  logic                              w_match;
  logic                              w_timeout_hit;

  // First eligible VC at or after rr_ptr, wrapping modulo N.
  always_comb begin
    w_found    = 1'b0;
    w_grant_vc = '0;
    w_cand     = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = rr_ptr_q + BUF_BITS'(i);
      if (!w_found && !buf_empty[w_cand] && (credit_q[w_cand] != '0)) begin
        w_found    = 1'b1;
        w_grant_vc = w_cand;
      end
    end
  end

  assign w_grant       = (state_q == S_IDLE) && w_found;
  assign w_match       = buf_valid && (buf_out_vc == cur_vc_q);
  assign w_timeout_hit = (state_q == S_WAIT) && !w_match && (wait_cnt_q == C_WAIT_LAST);

  // Return, refund and grant net out in one saturating sum per VC.
  for (genvar v = 0; v < N; v++) begin : g_credit
    logic                   w_inc_ret;
    logic                   w_inc_ref;
    logic                   w_dec;
    logic [CREDIT_BITS+1:0] w_sum;

    assign w_inc_ret = credit_in && (credit_vc == BUF_BITS'(v));
    assign w_inc_ref = w_timeout_hit && (cur_vc_q == BUF_BITS'(v));
    assign w_dec     = w_grant && (w_grant_vc == BUF_BITS'(v));
    assign w_sum     = {2'b00, credit_q[v]}
                     + (CREDIT_BITS+2)'(w_inc_ret)
                     + (CREDIT_BITS+2)'(w_inc_ref)
                     - (CREDIT_BITS+2)'(w_dec);
    assign credit_d[v] = (w_sum > {2'b00, C_CREDIT_MAX}) ? C_CREDIT_MAX : w_sum[CREDIT_BITS-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    read_vc_d   = read_vc_q;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    out_valid_d = out_valid_q;
    timeout_d   = timeout_q;
    rr_ptr_d    = rr_ptr_q;
    cur_vc_d    = cur_vc_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d   = S_ISSUE;
          rd_en_d   = 1'b1;
          read_vc_d = w_grant_vc;
          rr_ptr_d  = w_grant_vc + 1'b1;
          cur_vc_d  = w_grant_vc;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (w_match) begin
          out_data_d  = buf_read_data;
          out_vc_d    = cur_vc_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (w_timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      read_vc_q   <= '0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      rr_ptr_q    <= '0;
      cur_vc_q    <= '0;
      wait_cnt_q  <= '0;
      credit_q    <= {N{C_CREDIT_INIT}};
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      read_vc_q   <= read_vc_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_vc_q    <= cur_vc_d;
      wait_cnt_q  <= wait_cnt_d;
      credit_q    <= credit_d;
    end
  end

  assign buf_rdEn    = rd_en_q;
  assign buf_read_vc = read_vc_q;
  assign out_data    = out_data_q;
  assign out_vc      = out_vc_q;
  assign out_valid   = out_valid_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_read_scheduler.sv
`default_nettype none
// Bench for vc_read_scheduler: directed scenarios, then random transactions
// checked against a transaction-level credit/round-robin model.
module tb_vc_read_scheduler;

  localparam int DW   = 32;
  localparam int BB   = 1;
  localparam int CB   = 3;
  localparam int INIT = 4;
  localparam int TO   = 15;
  localparam int N    = 2;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  buf_empty = '1;
  logic          buf_rdEn;
  logic [BB-1:0] buf_read_vc;
  logic [DW-1:0] buf_read_data = '0;
  logic [BB-1:0] buf_out_vc = '0;
  logic          buf_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic [BB-1:0] out_vc;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          credit_in = 1'b0;
  logic [BB-1:0] credit_vc = '0;
  logic          timeout_err;

  vc_read_scheduler #(
    .DATA_WIDTH(DW), .BUF_BITS(BB), .CREDIT_BITS(CB), .INIT_CREDITS(INIT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .buf_empty(buf_empty), .buf_rdEn(buf_rdEn),
    .buf_read_vc(buf_read_vc), .buf_read_data(buf_read_data), .buf_out_vc(buf_out_vc),
    .buf_valid(buf_valid), .out_data(out_data), .out_vc(out_vc), .out_valid(out_valid),
    .out_ready(out_ready), .credit_in(credit_in), .credit_vc(credit_vc),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model state
  int cred [N];
  int rr;
  bit terr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic int pick(input logic [N-1:0] empty);
    for (int k = 0; k < N; k++) begin
      int v;
      v = (rr + k) % N;
      if (!empty[v] && cred[v] > 0) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) cred[v] = INIT;
    rr   = 0;
    terr = 1'b0;
  endtask

  task automatic check_credits();
    for (int v = 0; v < N; v++)
      chk($sformatf("credit_vc%0d", v), 64'(dut.credit_q[v]), 64'(cred[v]));
  endtask

  task automatic give_credit(input int v);
    buf_empty = '1;
    credit_in = 1'b1;
    credit_vc = BB'(v);
    tick();
    credit_in = 1'b0;
    cred[v] = sat(cred[v] + 1);
  endtask

  // One scheduling attempt. idle_waits < 0 means never answer (timeout).
  task automatic txn(input logic [N-1:0] empty, input int idle_waits, input int hold,
                     input bit junk, input int ret_vc, input bit credit_at_grant);
    int g;
    logic [DW-1:0] d;
    bit ret_pending;
    g = pick(empty);
    ret_pending = (ret_vc >= 0);
    buf_empty = empty;
    if (credit_at_grant && g >= 0) begin
      credit_in = 1'b1;
      credit_vc = BB'(g);
    end
    tick();
    credit_in = 1'b0;
    if (g < 0) begin
      chk("no_grant_rdEn", 64'(buf_rdEn), 64'(0));
      repeat (2) begin
        tick();
        chk("no_grant_rdEn", 64'(buf_rdEn), 64'(0));
      end
      buf_empty = '1;
      return;
    end
    chk("grant_rdEn", 64'(buf_rdEn), 64'(1));
    chk("grant_vc", 64'(buf_read_vc), 64'(g));
    cred[g] = sat(cred[g] + (credit_at_grant ? 1 : 0) - 1);
    rr = (g + 1) % N;
    tick();
    chk("rdEn_one_cycle", 64'(buf_rdEn), 64'(0));

    if (idle_waits < 0) begin
      for (int k = 0; k < TO - 1; k++) begin
        if (ret_pending) begin credit_in = 1'b1; credit_vc = BB'(ret_vc); end
        tick();
        if (ret_pending) begin credit_in = 1'b0; cred[ret_vc] = sat(cred[ret_vc] + 1); ret_pending = 0; end
        chk("wait_rdEn", 64'(buf_rdEn), 64'(0));
        chk("terr_before_timeout", 64'(timeout_err), 64'(terr));
      end
      tick();
      terr = 1'b1;
      cred[g] = sat(cred[g] + 1);
      chk("terr_timeout", 64'(timeout_err), 64'(1));
      chk("timeout_out_valid", 64'(out_valid), 64'(0));
      chk("timeout_rdEn", 64'(buf_rdEn), 64'(0));
      buf_empty = '1;
      return;
    end

    for (int k = 0; k < idle_waits; k++) begin
      if (junk && k == 0) begin
        buf_valid = 1'b1;
        buf_out_vc = BB'(g ^ 1);
        buf_read_data = $urandom;
      end
      if (ret_pending) begin credit_in = 1'b1; credit_vc = BB'(ret_vc); end
      tick();
      if (ret_pending) begin credit_in = 1'b0; cred[ret_vc] = sat(cred[ret_vc] + 1); ret_pending = 0; end
      buf_valid = 1'b0;
      chk("wait_out_valid", 64'(out_valid), 64'(0));
      chk("wait_rdEn", 64'(buf_rdEn), 64'(0));
    end
    d = $urandom;
    buf_valid = 1'b1;
    buf_out_vc = BB'(g);
    buf_read_data = d;
    if (ret_pending) begin credit_in = 1'b1; credit_vc = BB'(ret_vc); end
    tick();
    if (ret_pending) begin credit_in = 1'b0; cred[ret_vc] = sat(cred[ret_vc] + 1); ret_pending = 0; end
    buf_valid = 1'b0;
    buf_read_data = $urandom;
    chk("resp_out_valid", 64'(out_valid), 64'(1));
    chk("resp_out_data", 64'(out_data), 64'(d));
    chk("resp_out_vc", 64'(out_vc), 64'(g));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_out_data", 64'(out_data), 64'(d));
      chk("hold_out_vc", 64'(out_vc), 64'(g));
      chk("hold_rdEn", 64'(buf_rdEn), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_no_grant", 64'(buf_rdEn), 64'(0));
    buf_empty = '1;
  endtask

  initial begin
    // Reset state, applied before any clock edge
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_rdEn", 64'(buf_rdEn), 64'(0));
    chk("rst_read_vc", 64'(buf_read_vc), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_vc", 64'(out_vc), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    check_credits();
    tick();
    tick();
    reset = 1'b0;

    // Both VCs busy: alternating grants until credits run out
    for (int i = 0; i < 2 * INIT; i++) txn(2'b00, 1, 0, 0, -1, 0);
    check_credits();
    txn(2'b00, 1, 0, 0, -1, 0);
    repeat (3) give_credit(0);
    repeat (3) give_credit(1);

    // Only VC1 non-empty with rr at 0: grant VC1, pointer wraps to 0
    chk("rr_before_wrap", 64'(rr), 64'(0));
    txn(2'b01, 1, 0, 0, -1, 0);
    chk("rr_after_wrap", 64'(dut.rr_ptr_q), 64'(0));
    txn(2'b00, 0, 0, 0, -1, 0);

    // Timeout with credit refund
    txn(2'b00, -1, 0, 0, -1, 0);
    check_credits();
    txn(2'b00, 2, 0, 1, -1, 0);

    // Long hold with out_ready low while VCs stay non-empty
    txn(2'b00, 1, 10, 0, -1, 0);

    // Same-cycle credit return and grant, then saturation
    while (cred[0] > 2) txn(2'b10, 0, 0, 0, -1, 0);
    while (cred[0] < 2) give_credit(0);
    txn(2'b10, 1, 0, 0, -1, 1);
    chk("credit_same_cycle", 64'(dut.credit_q[0]), 64'(2));
    repeat (6) give_credit(0);
    chk("credit_saturate", 64'(dut.credit_q[0]), 64'(CMAX));

    // Asynchronous reset while waiting for a response
    buf_empty = 2'b10;
    tick();
    chk("pre_reset_grant", 64'(buf_rdEn), 64'(1));
    tick();
    tick();
    chk("pre_reset_terr", 64'(timeout_err), 64'(terr));
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_rdEn", 64'(buf_rdEn), 64'(0));
    chk("async_rst_read_vc", 64'(buf_read_vc), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_out_data", 64'(out_data), 64'(0));
    chk("async_rst_out_vc", 64'(out_vc), 64'(0));
    chk("async_rst_terr", 64'(timeout_err), 64'(0));
    check_credits();
    buf_empty = '1;
    #2 reset = 1'b0;
    tick();
    chk("post_reset_no_grant", 64'(buf_rdEn), 64'(0));
    txn(2'b01, 0, 0, 0, -1, 0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] e;
      int iw, h, rv;
      bit j, cg;
      e  = N'($urandom_range(0, 3));
      iw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      h  = int'($urandom_range(0, 3));
      j  = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 1));
      cg = ($urandom_range(0, 3) == 0);
      txn(e, iw, h, j, rv, cg);
      check_credits();
      chk("rand_terr", 64'(timeout_err), 64'(terr));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vc_read_scheduler.md
VC_READ_SCHEDULER -- requirements
Module: vc_read_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 Parameter BUF_BITS, default 1, VC index width; the number of VCs is N = 1 << BUF_BITS.
REQ-003 Parameter CREDIT_BITS, default 3, width of each per-VC credit counter.
REQ-004 Parameter INIT_CREDITS, default 4, credits per VC after reset; INIT_CREDITS SHALL be at most (1<<CREDIT_BITS)-1.
REQ-005 Parameter TIMEOUT, default 15, maximum number of WAIT cycles before abort.
REQ-006 Ports SHALL be:
- clk, input, 1: sole clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- buf_empty, input, N: per-VC empty flags from the upstream VC buffer port.
- buf_rdEn, output, 1: dequeue request to the buffer port.
- buf_read_vc, output, BUF_BITS: VC being dequeued.
- buf_read_data, input, DATA_WIDTH: returned flit.
- buf_out_vc, input, BUF_BITS: VC tag of the returned flit.
- buf_valid, input, 1: returned flit is valid.
- out_data, output, DATA_WIDTH: flit presented downstream.
- out_vc, output, BUF_BITS: VC of out_data.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the flit.
- credit_in, input, 1: downstream returns one credit.
- credit_vc, input, BUF_BITS: VC of the returned credit.
- timeout_err, output, 1: sticky flag, set on read timeout.

Function
REQ-007 The FSM SHALL have four states: IDLE, ISSUE, WAIT, HOLD; all outputs SHALL be registered.
REQ-008 A VC v is eligible when buf_empty[v]==0 and credit[v]>0.
REQ-009 In IDLE, the block SHALL grant the first eligible VC found searching from rr_ptr upward, modulo N.
- Outputs in the cycle after a grant: buf_rdEn=1, buf_read_vc=granted VC; state -> ISSUE.
- No eligible VC: remain in IDLE with buf_rdEn=0.
REQ-010 On a grant, the block SHALL:
- decrement credit[granted VC] by 1;
- set rr_ptr to (granted VC + 1) mod N;
- latch the granted VC in cur_vc.
REQ-011 In ISSUE, buf_rdEn SHALL return to 0 on the next edge (exactly one cycle high per grant); state -> WAIT; the wait counter is cleared.
REQ-012 In WAIT, on buf_valid==1 with buf_out_vc==cur_vc, the block SHALL:
- capture out_data=buf_read_data and out_vc=cur_vc;
- set out_valid=1 on the next edge;
- move to HOLD.
REQ-013 In WAIT, buf_valid with buf_out_vc!=cur_vc SHALL be ignored and the wait counter SHALL keep incrementing.
REQ-014 In WAIT, after TIMEOUT cycles with no matching response, the block SHALL:
- set timeout_err=1;
- restore credit[cur_vc] by 1, saturating at the maximum;
- return to IDLE.
REQ-015 In HOLD, out_data, out_vc and out_valid SHALL stay stable until out_ready==1.
- On that edge: out_valid=0, state -> IDLE.
- No new grant is made in the same cycle; the minimum spacing between flits is 4 cycles.
REQ-016 Only one dequeue SHALL be in flight at a time; buf_rdEn SHALL never be high outside the cycle after a grant.
REQ-017 credit_in==1 SHALL increment credit[credit_vc] by 1, saturating at (1<<CREDIT_BITS)-1 with no wrap.
REQ-018 A credit return and a grant decrement on the same VC in the same cycle SHALL leave that credit unchanged.
REQ-019 Credit returns SHALL be accepted in every state, including HOLD and WAIT.
REQ-020 The rr_ptr arithmetic SHALL wrap from N-1 to 0.
REQ-021 buf_empty SHALL be sampled only in IDLE.

Reset
REQ-022 While reset==1, asynchronously and independent of clk, the block SHALL force:
- state=IDLE;
- buf_rdEn=0, buf_read_vc=0;
- out_valid=0, out_data=0, out_vc=0;
- timeout_err=0;
- rr_ptr=0, cur_vc=0, wait counter=0;
- every credit[v]=INIT_CREDITS.
REQ-023 A reset asserted mid-operation (ISSUE, WAIT or HOLD) SHALL abandon the in-flight flit without a credit refund; the first grant is possible on the first edge after reset deasserts.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Both VCs non-empty, credits 4, out_ready=1, upstream returns valid 2 cycles after buf_rdEn -> grants alternate VC0, VC1, VC0, ...; each VC reaches credit 0 after 4 grants; no further buf_rdEn until credit_in.
- VC1 alone non-empty, rr_ptr=0 -> buf_read_vc=1; rr_ptr becomes 0 (wrap).
- No buf_valid for 15 WAIT cycles -> timeout_err=1; credit restored to its prior value; state IDLE.
- out_ready held 0 for 10 cycles in HOLD -> out_data and out_vc stable, out_valid=1, buf_rdEn=0 throughout.
- credit_in on VC0 in the same cycle as a VC0 grant with credit 2 -> credit stays 2; credit_in at credit 7 -> stays 7.
- reset asserted in WAIT, between clock edges -> outputs zero immediately; credits=4; no buf_rdEn in the cycle after deassertion if all VCs are empty.
